// File: rtl/dc_window_sequencer_if.sv
// Stream port of dc_window_sequencer: one count word per transfer, last word of a
// window frame flagged with tlast.
interface dc_window_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dc_window_sequencer.sv
// dc_window_sequencer: paces the shared latch/clear pulse of a bin_counter array at a
// programmable integration period, then reads every latched count through the channel
// mux and streams it out as one frame per window.
// Build option: define DC_HEADER_EN to prefix every frame with the words
// 0xDC00|N_CH[7:0] and the pre-increment frame count.
module dc_window_sequencer #(
  parameter int N_CH     = 64,
  parameter int CNT_W    = 16,
  parameter int PERIOD_W = 32,
  parameter int READ_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic [PERIOD_W-1:0]     int_period_i,
  output logic                    latch_out_o,
  output logic [$clog2(N_CH)-1:0] ch_sel_o,
  input  logic [CNT_W-1:0]        ch_count_i,
  dc_window_sequencer_if.master   m_axis,
  output logic [15:0]             frame_cnt_o,
  output logic                    overrun_o,
  input  logic                    overrun_clr_i
);

  localparam int SEL_W = $clog2(N_CH);
`ifdef DC_HEADER_EN
  localparam int HDR_WORDS = 2;
`else
  localparam int HDR_WORDS = 0;
`endif
  localparam int WORDS = N_CH + HDR_WORDS;
  localparam int WD_W  = $clog2(WORDS + 1);
  localparam int LAT_W = $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {IDLE, PRIME, INTEGRATE, LATCH, READ} state_t;

  state_t               state_q, state_d;
  logic [PERIOD_W-1:0]  perCnt_q, perCnt_d;
  logic [WD_W-1:0]      wordIdx_q, wordIdx_d;
  logic [SEL_W-1:0]     chSel_q, chSel_d;
  logic [LAT_W-1:0]     latCnt_q, latCnt_d;
  logic [CNT_W-1:0]     tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [15:0]          frameCnt_q, frameCnt_d;
  logic                 overrun_q, overrun_d;

  logic                 latchOut;
  logic                 frameDone;
  logic [CNT_W-1:0]     wordData;
  logic [SEL_W-1:0]     chSelNext;
  logic [PERIOD_W-1:0]  periodLoad;
  logic [PERIOD_W-1:0]  perDec;
  logic                 periodExpired;
  logic                 lastWord;

  // Short periods are clamped to 4; the counter is loaded one low so the latch lands
  // exactly int_period cycles after the previous one.
  always_comb begin
    if (int_period_i < PERIOD_W'(4)) periodLoad = PERIOD_W'(3);
    else                             periodLoad = int_period_i - PERIOD_W'(1);
    perDec        = (perCnt_q == '0) ? '0 : perCnt_q - PERIOD_W'(1);
    periodExpired = (perCnt_q <= PERIOD_W'(1));
    lastWord      = (wordIdx_q == WD_W'(WORDS - 1));
  end

  // Picks the payload of the current word and the channel to select after it.
  always_comb begin
    wordData  = ch_count_i;
    chSelNext = chSel_q + SEL_W'(1);
`ifdef DC_HEADER_EN
    if (wordIdx_q == WD_W'(0)) wordData = CNT_W'(16'hDC00 | 16'(N_CH % 256));
    else if (wordIdx_q == WD_W'(1)) wordData = CNT_W'(frameCnt_q);
    if (wordIdx_q < WD_W'(HDR_WORDS)) chSelNext = '0;
`endif
  end

  // Window FSM: period countdown, latch pulses, readout handshake and frame bookkeeping.
  always_comb begin
    state_d    = state_q;
    perCnt_d   = perCnt_q;
    wordIdx_d  = wordIdx_q;
    chSel_d    = chSel_q;
    latCnt_d   = latCnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    frameCnt_d = frameCnt_q;
    overrun_d  = overrun_q & ~overrun_clr_i;
    latchOut   = 1'b0;
    frameDone  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = PRIME;
      end
      PRIME: begin
        latchOut = 1'b1;
        perCnt_d = periodLoad;
        state_d  = INTEGRATE;
      end
      INTEGRATE: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else begin
          perCnt_d = perDec;
          if (periodExpired) state_d = LATCH;
        end
      end
      LATCH: begin
        latchOut  = 1'b1;
        perCnt_d  = periodLoad;
        wordIdx_d = '0;
        chSel_d   = '0;
        latCnt_d  = '0;
        state_d   = READ;
      end
      READ: begin
        perCnt_d = perDec;
        if (!tvalid_q) begin
          if (latCnt_q == LAT_W'(READ_LAT - 1)) begin
            tdata_d  = wordData;
            tlast_d  = lastWord;
            tvalid_d = 1'b1;
          end else begin
            latCnt_d = latCnt_q + LAT_W'(1);
          end
        end else if (m_axis.tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          latCnt_d = '0;
          if (lastWord) begin
            frameDone  = 1'b1;
            frameCnt_d = frameCnt_q + 16'd1;
            wordIdx_d  = '0;
            chSel_d    = '0;
            if (!enable_i)          state_d = IDLE;
            else if (periodExpired) state_d = LATCH;
            else                    state_d = INTEGRATE;
          end else begin
            wordIdx_d = wordIdx_q + WD_W'(1);
            chSel_d   = chSelNext;
          end
        end
        if ((perCnt_q == PERIOD_W'(1)) && !frameDone) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      perCnt_q   <= '0;
      wordIdx_q  <= '0;
      chSel_q    <= '0;
      latCnt_q   <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      frameCnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      perCnt_q   <= perCnt_d;
      wordIdx_q  <= wordIdx_d;
      chSel_q    <= chSel_d;
      latCnt_q   <= latCnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      frameCnt_q <= frameCnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign latch_out_o   = latchOut;
  assign ch_sel_o      = chSel_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign frame_cnt_o   = frameCnt_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_dc_window_sequencer.sv
// Testbench for dc_window_sequencer: models a small bin_counter array behind a
// zero-wait mux, predicts every frame when a latch pulse appears and compares the
// stream against that prediction.
module tb_dc_window_sequencer;

  localparam int N_CH     = 4;
  localparam int CNT_W    = 16;
  localparam int PERIOD_W = 32;
  localparam int READ_LAT = 1;
`ifdef DC_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int FL = N_CH + HDR;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic                overrunClr = 1'b0;
  logic [PERIOD_W-1:0] intPeriod = 32'd100;
  logic                tready = 1'b0;
  logic                latchOut;
  logic [1:0]          chSel;
  logic [CNT_W-1:0]    chCount;
  logic [15:0]         frameCnt;
  logic                overrun;

  dc_window_sequencer_if #(.CNT_W(CNT_W)) axis ();
  assign axis.tready = tready;

  dc_window_sequencer #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD_W(PERIOD_W), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .reset(reset), .enable_i(enable), .int_period_i(intPeriod),
    .latch_out_o(latchOut), .ch_sel_o(chSel), .ch_count_i(chCount),
    .m_axis(axis), .frame_cnt_o(frameCnt), .overrun_o(overrun),
    .overrun_clr_i(overrunClr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } word_t;

  logic [15:0] latchVal [N_CH];
  assign chCount = latchVal[chSel];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  word_t expQ[$];
  int    framesDone = 0;
  int    framesPushed = 0;
  int    valSeed = 0;
  int    latchCount = 0;
  int    wordIdx = 0;
  int    lastLatchCyc = -1;
  int    expGap = 0;
  int    tlastCyc = -1;
  bit    skipPrime = 0;
  bit    expectDeferred = 0;
  bit    fcPending = 0;
  bit    prevStall = 0;
  bit    prevLatch = 0;
  logic [15:0] prevData = '0;
  logic        prevLast = 1'b0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counter array model: new counts appear at each latch, expected frame is queued.
  task automatic pushFrame();
    for (int i = 0; i < N_CH; i++) latchVal[i] = 16'(5 + i + 16 * valSeed);
    valSeed++;
`ifdef DC_HEADER_EN
    expQ.push_back('{data: 16'hDC00 | 16'(N_CH), last: 1'b0});
    expQ.push_back('{data: 16'(framesPushed), last: 1'b0});
`endif
    for (int i = 0; i < N_CH; i++)
      expQ.push_back('{data: latchVal[i], last: (i == N_CH - 1)});
    framesPushed++;
  endtask

  always @(posedge clk) cyc++;

  // Monitor on the falling edge: scoreboard pops, stall stability, latch rules.
  always @(negedge clk) begin
    word_t w;
    if (!reset) begin
      if (fcPending) begin
        checkOutput("frameCnt", {16'd0, frameCnt}, 32'(framesDone % 65536));
        fcPending = 0;
      end
      if (prevStall) begin
        checkOutput("stallValid", {31'd0, axis.tvalid}, 32'd1);
        checkOutput("stallData", {16'd0, axis.tdata}, {16'd0, prevData});
        checkOutput("stallLast", {31'd0, axis.tlast}, {31'd0, prevLast});
      end
      prevStall = axis.tvalid && !tready;
      prevData  = axis.tdata;
      prevLast  = axis.tlast;
      if (axis.tvalid && tready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedWord", 32'd1, 32'd0);
        end else begin
          w = expQ.pop_front();
          checkOutput("tdata", {16'd0, axis.tdata}, {16'd0, w.data});
          checkOutput("tlast", {31'd0, axis.tlast}, {31'd0, w.last});
        end
        wordIdx = (wordIdx + 1) % FL;
        if (wordIdx == 0) begin
          framesDone++;
          fcPending = 1;
          tlastCyc  = cyc;
        end
      end
      if (latchOut) begin
        latchCount++;
        checkOutput("latchB2B", {31'd0, prevLatch}, 32'd0);
        checkOutput("latchInRead", 32'((wordIdx != 0) || axis.tvalid), 32'd0);
        if (skipPrime) begin
          skipPrime = 0;
        end else begin
          if (expGap != 0 && lastLatchCyc >= 0)
            checkOutput("latchGap", 32'(cyc - lastLatchCyc), 32'(expGap));
          if (expectDeferred) begin
            checkOutput("deferredLatch", 32'(cyc - tlastCyc), 32'd1);
            expectDeferred = 0;
          end
          pushFrame();
        end
        lastLatchCyc = cyc;
      end
      prevLatch = latchOut;
    end
  end

  // Advances one cycle and drives tready: 0 = always ready, 1 = one of three, 2 = stalled.
  task automatic stepCycle(input int mode);
    @(posedge clk);
    #1;
    case (mode)
      0:       tready = 1'b1;
      1:       tready = (cyc % 3 == 0);
      default: tready = 1'b0;
    endcase
  endtask

  task automatic runCycles(input int n, input int mode);
    repeat (n) stepCycle(mode);
  endtask

  task automatic waitFrames(input int target, input int budget, input int mode, input string tag);
    int n = 0;
    while (framesDone < target && n < budget) begin
      stepCycle(mode);
      n++;
    end
    checkOutput(tag, 32'(framesDone), 32'(target));
  endtask

  task automatic waitValid(input int budget, input int mode, input string tag);
    int n = 0;
    while (!axis.tvalid && n < budget) begin
      stepCycle(mode);
      n++;
    end
    checkOutput(tag, {31'd0, axis.tvalid}, 32'd1);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    enable = 1'b0;
    tready = 1'b0;
    overrunClr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expQ.delete();
    framesDone = 0;
    framesPushed = 0;
    wordIdx = 0;
    lastLatchCyc = -1;
    expGap = 0;
    skipPrime = 0;
    expectDeferred = 0;
    fcPending = 0;
    prevStall = 0;
    prevLatch = 0;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input int testId);
    int base;
    int n;
    case (testId)
      // Nominal windows, always-ready sink, reset values first.
      1: begin
        resetDut();
        @(negedge clk);
        checkOutput("rstLatch", {31'd0, latchOut}, 32'd0);
        checkOutput("rstValid", {31'd0, axis.tvalid}, 32'd0);
        checkOutput("rstFrameCnt", {16'd0, frameCnt}, 32'd0);
        checkOutput("rstOverrun", {31'd0, overrun}, 32'd0);
        checkOutput("rstChSel", {30'd0, chSel}, 32'd0);
        intPeriod = 32'd100;
        expGap = 100;
        skipPrime = 1;
        enable = 1'b1;
        waitFrames(2, 400, 0, "s1Frames");
        enable = 1'b0;
        base = latchCount;
        runCycles(150, 0);
        checkOutput("s1NoLatchIdle", 32'(latchCount - base), 32'd0);
        checkOutput("s1QueueEmpty", 32'(expQ.size()), 32'd0);
      end
      // Sink ready one cycle in three.
      2: begin
        resetDut();
        intPeriod = 32'd100;
        expGap = 100;
        skipPrime = 1;
        enable = 1'b1;
        waitFrames(3, 600, 1, "s2Frames");
        enable = 1'b0;
        runCycles(20, 1);
        checkOutput("s2QueueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("s2Overrun", {31'd0, overrun}, 32'd0);
      end
      // Short period with a stalled sink: overrun and one deferred latch.
      3: begin
        resetDut();
        intPeriod = 32'd2;
        expGap = 0;
        skipPrime = 1;
        enable = 1'b1;
        waitValid(50, 2, "s3FirstValid");
        runCycles(20, 2);
        @(negedge clk);
        checkOutput("s3OverrunSet", {31'd0, overrun}, 32'd1);
        expectDeferred = 1;
        waitFrames(1, 100, 0, "s3Frame1");
        enable = 1'b0;
        waitFrames(2, 100, 0, "s3Frame2");
        checkOutput("s3DeferredSeen", {31'd0, expectDeferred}, 32'd0);
        base = latchCount;
        runCycles(30, 0);
        checkOutput("s3NoLatchIdle", 32'(latchCount - base), 32'd0);
        @(negedge clk);
        checkOutput("s3OverrunSticky", {31'd0, overrun}, 32'd1);
        @(posedge clk);
        #1 overrunClr = 1'b1;
        @(posedge clk);
        #1 overrunClr = 1'b0;
        @(negedge clk);
        checkOutput("s3OverrunClr", {31'd0, overrun}, 32'd0);
        checkOutput("s3QueueEmpty", 32'(expQ.size()), 32'd0);
      end
      // Enable dropped in the middle of a readout.
      4: begin
        resetDut();
        intPeriod = 32'd100;
        expGap = 100;
        skipPrime = 1;
        enable = 1'b1;
        waitValid(200, 2, "s4FirstValid");
        runCycles(3, 2);
        enable = 1'b0;
        runCycles(5, 2);
        waitFrames(1, 100, 0, "s4Frame");
        base = latchCount;
        runCycles(150, 0);
        checkOutput("s4NoLatchAfter", 32'(latchCount - base), 32'd0);
        @(negedge clk);
        checkOutput("s4ValidLow", {31'd0, axis.tvalid}, 32'd0);
        checkOutput("s4QueueEmpty", 32'(expQ.size()), 32'd0);
      end
      // Reset in the middle of the second word of a frame.
      5: begin
        resetDut();
        intPeriod = 32'd100;
        expGap = 100;
        skipPrime = 1;
        enable = 1'b1;
        waitFrames(1, 300, 0, "s5Frame1");
        n = 0;
        while (wordIdx != 1 && n < 300) begin
          stepCycle(0);
          n++;
        end
        checkOutput("s5Word2Reached", 32'(wordIdx), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("s5RstValid", {31'd0, axis.tvalid}, 32'd0);
        checkOutput("s5RstLatch", {31'd0, latchOut}, 32'd0);
        checkOutput("s5RstFrameCnt", {16'd0, frameCnt}, 32'd0);
        resetDut();
      end
      default: ;
    endcase
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) latchVal[i] = '0;
    for (int t = 1; t <= 5; t++) applyStimulus(t);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
